// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM interrupt aggregator.
// The block collects NUM_IRQ request lines and latches each one as pending,
// either on a rising edge or by following its level, as set per line. It
// masks the pending bits, priority-encodes them and drives one CPU interrupt.
// The slave interface is 16 bits wide with a 3-bit word address and a read
// latency of one clock. This matches the interval timer core.
//
// Optional feature: define IRQ_AGG_SYNC_EN to add two synchronizer flops
// ahead of the input stage. Use it when the sources are asynchronous or come
// from a foreign clock. It adds two cycles of input latency.
//
// Register map (word address):
//   0 PENDING  RO, write-1-to-clear (edge-mode lines only)
//   1 MASK     RW, reset 0
//   2 ACTIVE   RO, PENDING & MASK
//   3 HIGHEST  RO, {valid, 11'b0, idx[3:0]}, lowest-numbered active line
//   4 EDGE_SEL RW, reset all ones (1 = edge, 0 = level)
//   5 SWSET    WO, write-1-to-set PENDING (edge-mode lines only)
//   6,7        read 0, writes ignored
// NUM_IRQ ranges over 1..16. Register bits at NUM_IRQ and above read 0.

module irq_aggregator #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  // Word addresses of the register file. All eight codes are named, so a
  // cast of the raw address always lands on a legal value.
  typedef enum logic [2:0] {
    ADDR_PENDING  = 3'd0,
    ADDR_MASK     = 3'd1,
    ADDR_ACTIVE   = 3'd2,
    ADDR_HIGHEST  = 3'd3,
    ADDR_EDGE_SEL = 3'd4,
    ADDR_SWSET    = 3'd5,
    ADDR_RSVD6    = 3'd6,
    ADDR_RSVD7    = 3'd7
  } reg_addr_e;

  localparam logic [NUM_IRQ-1:0] ALL_ONES = '1;

  // Input stage
  logic [NUM_IRQ-1:0] irq_src;     // request lines as seen by irq_q
  logic [NUM_IRQ-1:0] irq_q;       // first (or only) clk-domain sample
  logic [NUM_IRQ-1:0] irq_d;       // one-cycle-delayed copy for edge detect
  logic [NUM_IRQ-1:0] rise;

  // Register file
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mask_nxt;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] active;

  // Bus decode
  logic               wr_en;
  logic               wr_pending;
  logic               wr_mask;
  logic               wr_edge_sel;
  logic               wr_swset;
  logic [NUM_IRQ-1:0] wdata_irq;
  logic [NUM_IRQ-1:0] set_bits;
  logic [NUM_IRQ-1:0] clr_bits;
  logic               unused_wdata;

  // Priority encoder and read path
  logic               hi_valid;
  logic [3:0]         hi_idx;
  logic [15:0]        read_mux;

  // ---------------------------------------------------------------------------
  // Bus write decode. A write needs chipselect. Reads do not.
  // ---------------------------------------------------------------------------
  assign wr_en       = chipselect & ~write_n;
  assign wr_pending  = wr_en && (address == ADDR_PENDING);
  assign wr_mask     = wr_en && (address == ADDR_MASK);
  assign wr_edge_sel = wr_en && (address == ADDR_EDGE_SEL);
  assign wr_swset    = wr_en && (address == ADDR_SWSET);

  // Only the low NUM_IRQ data bits reach a register. The upper bits are
  // folded into a sink so they are visibly consumed.
  assign wdata_irq    = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Optional synchronizer ahead of the input stage
  // ---------------------------------------------------------------------------
`ifdef IRQ_AGG_SYNC_EN
  logic [NUM_IRQ-1:0] sync_1;
  logic [NUM_IRQ-1:0] sync_2;

  // Two-flop synchronizer. Reset clears it, so an input held high through
  // reset is still detected as an edge afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= irq_in;
      sync_2 <= sync_1;
    end
  end

  assign irq_src = sync_2;
`else
  assign irq_src = irq_in;
`endif

  // Input sample and delayed copy. A rise is a 1 in irq_q over a 0 in irq_d.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking '<=' so every flop samples pre-edge
    // values no matter how the statements are ordered.
    if (reset) begin
      irq_q <= '0;
      irq_d <= '0;
    end else begin
      irq_q <= irq_src;
      irq_d <= irq_q;
    end
  end

  assign rise = irq_q & ~irq_d;

  // ---------------------------------------------------------------------------
  // Next-state logic for PENDING and MASK
  // ---------------------------------------------------------------------------
  // Edge-mode lines set on a rise or a SWSET bit and clear on a W1C bit. If
  // both happen in the same cycle, set wins. Level-mode lines copy irq_q and
  // ignore both strobes. The mode is taken from the current EDGE_SEL, so a
  // new mode applies from the cycle after it is written.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition.
    // Without that, a path that skips an assignment would infer a latch.
    set_bits    = rise;
    clr_bits    = '0;
    pending_nxt = pending;
    mask_nxt    = mask;

    if (wr_swset) begin
      set_bits = rise | wdata_irq;
    end
    if (wr_pending) begin
      clr_bits = wdata_irq;
    end
    if (wr_mask) begin
      mask_nxt = wdata_irq;
    end

    pending_nxt = (edge_sel & (set_bits | (pending & ~clr_bits)))
                | (~edge_sel & irq_q);
  end

  // Register file state. irq_out is registered from the next-state values.
  // A pending set, a W1C or a MASK write therefore shows on irq_out right
  // after the edge that commits it. No combinational path runs from irq_in
  // or the bus to the pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      edge_sel <= ALL_ONES;
      irq_out  <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      mask     <= mask_nxt;
      if (wr_edge_sel) begin
        edge_sel <= wdata_irq;
      end
      irq_out  <= |(pending_nxt & mask_nxt);
    end
  end

  assign active = pending & mask;

  // ---------------------------------------------------------------------------
  // HIGHEST: lowest-numbered active line
  // ---------------------------------------------------------------------------
  // The scan runs from the top bit down, so the last hit is the lowest index.
  // The output is all zero when nothing is active.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        hi_valid = 1'b1;
        hi_idx   = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // The read mux works on current register contents. A read in the same
  // cycle as a write to that register returns the pre-write value.
  always_comb begin
    read_mux = '0;
    case (reg_addr_e'(address))
      ADDR_PENDING:  read_mux[NUM_IRQ-1:0] = pending;
      ADDR_MASK:     read_mux[NUM_IRQ-1:0] = mask;
      ADDR_ACTIVE:   read_mux[NUM_IRQ-1:0] = active;
      ADDR_HIGHEST:  read_mux              = {hi_valid, 11'd0, hi_idx};
      ADDR_EDGE_SEL: read_mux[NUM_IRQ-1:0] = edge_sel;
      default:       read_mux              = '0;  // SWSET is write-only; 6,7 reserved
    endcase
  end

  // Registered read data. It is updated every cycle from the address, so the
  // value for an address appears one clock after that address is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: self-checking bench for irq_aggregator.
// The directed steps follow the documented scenarios and compare against
// constants. A randomized phase follows. Every clock is compared against a
// behavioural model that holds the register contents and a short history of
// sampled request lines.
module tb_irq_aggregator;

  localparam int NUM_IRQ = 8;
`ifdef IRQ_AGG_SYNC_EN
  localparam int DLY = 3;
`else
  localparam int DLY = 1;
`endif
  localparam int          EXTRA = DLY - 1;
  localparam logic [15:0] FULL  = 16'((32'd1 << NUM_IRQ) - 32'd1);

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [15:0] irq_v;
  logic        irq_out;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_pend;
  logic [15:0] m_mask;
  logic [15:0] m_edge;
  logic [15:0] m_rd;
  logic        m_irq;
  logic [15:0] hist[$];   // irq_in samples from the last DLY+1 edges, oldest first

  irq_aggregator #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_v[NUM_IRQ-1:0]),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lowest_active(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      if (v[i]) return 16'h8000 | 16'(i);
    end
    return 16'h0000;
  endfunction

  // Apply one rising edge to the model, using the inputs the DUT sees now.
  task automatic model_edge();
    logic [15:0] q, d, rise, ws, wc, np, nm;
    logic        wr;
    if (reset) begin
      m_pend = '0;
      m_mask = '0;
      m_edge = FULL;
      m_rd   = '0;
      m_irq  = 1'b0;
      hist   = {};
      for (int i = 0; i <= DLY; i++) hist.push_back(16'h0);
    end else begin
      q    = hist[1];
      d    = hist[0];
      rise = q & ~d;
      wr   = chipselect && !write_n;
      ws   = (wr && address == 3'd5) ? (writedata & FULL) : 16'h0;
      wc   = (wr && address == 3'd0) ? (writedata & FULL) : 16'h0;
      case (address)
        3'd0:    m_rd = m_pend;
        3'd1:    m_rd = m_mask;
        3'd2:    m_rd = m_pend & m_mask;
        3'd3:    m_rd = lowest_active(m_pend & m_mask);
        3'd4:    m_rd = m_edge;
        default: m_rd = 16'h0;
      endcase
      np = 16'h0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (m_edge[i]) begin
          if (rise[i] || ws[i])  np[i] = 1'b1;
          else if (wc[i])        np[i] = 1'b0;
          else                   np[i] = m_pend[i];
        end else begin
          np[i] = q[i];
        end
      end
      nm = (wr && address == 3'd1) ? (writedata & FULL) : m_mask;
      if (wr && address == 3'd4) m_edge = writedata & FULL;
      m_pend = np;
      m_mask = nm;
      m_irq  = (np & nm) != 16'h0;
      hist.push_back(irq_v & FULL);
      void'(hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_readdata", readdata, m_rd);
    check("model_irq_out", {15'd0, irq_out}, {15'd0, m_irq});
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0;
    irq_v      = 16'h0;

    // 1: reset values
    repeat (3) tick();
    check("t1_readdata_reset", readdata, 16'h0000);
    check("t1_irq_out_reset", {15'd0, irq_out}, 16'h0000);
    reset = 1'b0;
    bus_read(3'd1);
    check("t1_mask_reset", readdata, 16'h0000);
    bus_read(3'd4);
    check("t1_edge_sel_reset", readdata, 16'h00FF);

    // 2: single-cycle pulse on line 0, then W1C
    bus_write(3'd1, 16'h0001);
    irq_v = 16'h0001;
    tick();
    irq_v = 16'h0000;
    repeat (EXTRA) tick();
    check("t2_irq_out_early", {15'd0, irq_out}, 16'h0000);
    tick();
    check("t2_irq_out_set", {15'd0, irq_out}, 16'h0001);
    bus_read(3'd0);
    check("t2_pending", readdata, 16'h0001);
    bus_write(3'd0, 16'h0001);
    check("t2_irq_out_cleared", {15'd0, irq_out}, 16'h0000);

    // 3: SWSET, ACTIVE, HIGHEST
    bus_write(3'd5, 16'h000A);
    bus_write(3'd1, 16'h00FF);
    bus_read(3'd2);
    check("t3_active", readdata, 16'h000A);
    check("t3_irq_out", {15'd0, irq_out}, 16'h0001);
    bus_read(3'd3);
    check("t3_highest", readdata, 16'h8001);
    bus_write(3'd0, 16'h0002);
    bus_read(3'd3);
    check("t3_highest_after_w1c", readdata, 16'h8003);

    // 4: set wins over W1C in the same cycle
    bus_write(3'd0, 16'hFFFF);
    irq_v = 16'h0004;
    tick();
    repeat (EXTRA) tick();
    bus_write(3'd0, 16'h0004);
    irq_v = 16'h0000;
    bus_read(3'd0);
    check("t4_set_wins", readdata, 16'h0004);

    // 5: level mode on line 3
    bus_write(3'd4, 16'h00F7);
    irq_v = 16'h0008;
    tick();
    repeat (EXTRA) tick();
    tick();
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0);
    check("t5_level_ignores_w1c", readdata, 16'h000C);
    irq_v = 16'h0000;
    tick();
    repeat (EXTRA) tick();
    tick();
    check("t5_level_still_high", readdata, 16'h000C);
    tick();
    check("t5_level_dropped", readdata, 16'h0004);

    // 6: reset clears everything; a held input re-pends after release
    bus_write(3'd4, 16'h00FF);
    bus_write(3'd5, 16'h00FF);
    irq_v = 16'h0020;
    bus_read(3'd0);
    check("t6_pending_full", readdata, 16'h00FF);
    reset = 1'b1;
    tick();
    check("t6_readdata_reset", readdata, 16'h0000);
    check("t6_irq_out_reset", {15'd0, irq_out}, 16'h0000);
    reset   = 1'b0;
    address = 3'd0;
    tick();
    repeat (EXTRA) tick();
    tick();
    check("t6_not_yet_pending", readdata, 16'h0000);
    tick();
    check("t6_repend", readdata, 16'h0020);

    // Randomized traffic against the model
    irq_v = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 299) == 0);
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = (($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 15)));
      irq_v      = irq_v ^ 16'($urandom & $urandom & $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
